// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder built around the single-bit full-adder cell `adder`.
// Optional subtract mode is enabled with `define SERIAL_ADD_SUB_EN (adds a `sub` input).

module adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic c
);
   assign sum = a ^ b ^ cin;
   assign c   = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_sh, b_sh, psum;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             load, shift_en, finish;
   logic             busy_n, done_n;
   logic [WIDTH-1:0] b_load;
   logic             cin_load;
   logic             bit_sum, bit_c;

`ifdef SERIAL_ADD_SUB_EN
   // Subtraction as A + ~B + 1; cout=1 then means no borrow.
   assign b_load   = sub ? ~b_in : b_in;
   assign cin_load = sub ? 1'b1  : cin_in;
`else
   assign b_load   = b_in;
   assign cin_load = cin_in;
`endif

   adder u_adder (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (carry),
      .sum (bit_sum),
      .c   (bit_c)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = SHIFT;
         SHIFT:   if (last)  state_n = DONE;
         DONE:    state_n = start ? SHIFT : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      load     = start && (state == IDLE || state == DONE);
      shift_en = (state == SHIFT);
      finish   = shift_en && last;
      busy_n   = (state_n == SHIFT);
      done_n   = (state_n == DONE);
   end

   // Datapath and registered outputs; result registers move only on the completion edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         sum_out <= '0;
         cout    <= 1'b0;
         a_sh    <= '0;
         b_sh    <= '0;
         psum    <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
      end else begin
         busy <= busy_n;
         done <= done_n;
         if (load) begin
            a_sh  <= a_in;
            b_sh  <= b_load;
            carry <= cin_load;
            cnt   <= '0;
            psum  <= '0;
         end else if (shift_en) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            psum  <= {bit_sum, psum[WIDTH-1:1]};
            carry <= bit_c;
            if (!last) cnt <= cnt + CW'(1);
         end
         if (finish) begin
            sum_out <= {bit_sum, psum[WIDTH-1:1]};
            cout    <= bit_c;
         end
      end
   end

endmodule
